pkt_buf_cache: RTL

Packet data cache directly downstream of the ingress buffer manager. Stores each accepted 134-bit-line packet into one of BUF_NUM fixed-size buffers and reports the allocated buffer ID and the free-buffer count back upstream. Reclaims the buffer of every packet whose end-of-packet valid flag is 0. Serves by-ID read requests from the output scheduler, then frees the buffer.

---
 rtl/pkt_buf_pkg.sv | 21 ++
 rtl/pkt_buf_free_map.sv | 53 +++++
 rtl/pkt_buf_cache.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_buf_pkg.sv
// Shared types and constants for the packet buffer cache.
package pkt_buf_pkg;

  localparam int ID_W    = 8;
  localparam int MAX_BUF = 16;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} wr_state_e;
  typedef enum logic       {R_IDLE, R_READ}          rd_state_e;

  function automatic logic [4:0] popcount(input logic [MAX_BUF-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < MAX_BUF; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/pkt_buf_free_map.sv
// Free-buffer bitmap (1 = free) with lowest-free allocation and a free count
// that reflects the map as it will be after this cycle's alloc/free.
module pkt_buf_free_map
  import pkt_buf_pkg::*;
#(
  parameter int BUF_NUM = 16,
  localparam int BW = $clog2(BUF_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_alloc,
  output logic [BW-1:0]      o_alloc_id,
  output logic               o_any_free,
  input  logic [BUF_NUM-1:0] i_free_mask,
  output logic [4:0]         o_free_cnt
);

  logic [BUF_NUM-1:0] r_map;
  logic [BUF_NUM-1:0] w_map_nxt;
  logic [BUF_NUM-1:0] w_alloc_mask;
  logic [4:0]         r_cnt;

  always_comb begin
    o_alloc_id = '0;
    o_any_free = 1'b0;
    for (int i = BUF_NUM - 1; i >= 0; i--) begin
      if (r_map[i]) begin
        o_alloc_id = BW'(i);
        o_any_free = 1'b1;
      end
    end
  end

  // Alloc chooses from the current map, so a same-cycle free is never re-picked.
  always_comb begin
    w_alloc_mask = '0;
    if (i_alloc) w_alloc_mask[o_alloc_id] = 1'b1;
    w_map_nxt = (r_map & ~w_alloc_mask) | i_free_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_map <= '1;
      r_cnt <= 5'(BUF_NUM);
    end else begin
      r_map <= w_map_nxt;
      r_cnt <= popcount(MAX_BUF'(w_map_nxt));
    end
  end

  assign o_free_cnt = r_cnt;

endmodule

// File: rtl/pkt_buf_cache.sv
// Packet buffer cache: stores packets into fixed buffers, serves reads by ID.
// Optional drop counter port enabled by defining PKT_BUF_DROP_CNT_EN.
//
// state   | meaning
// W_IDLE  | waiting for a head line
// W_STORE | writing lines of an allocated packet
// W_DROP  | discarding lines until a tail (no buffer was free)
// R_IDLE  | waiting for a read request
// R_READ  | streaming lines, then one cycle to release the buffer
module pkt_buf_cache
  import pkt_buf_pkg::*;
#(
  parameter int BUF_NUM   = 16,
  parameter int MAX_LINES = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [133:0]    in_data,
  input  logic            in_data_wr,
  input  logic            in_valid,
  input  logic            in_valid_wr,
  output logic [ID_W-1:0] out_cur_id,
  output logic [4:0]      out_free_cnt,
  input  logic [ID_W-1:0] rd_req_id,
  input  logic            rd_req_wr,
  output logic [133:0]    out_data,
  output logic            out_data_wr,
  output logic            out_rd_err
`ifdef PKT_BUF_DROP_CNT_EN
  ,
  output logic [15:0]     out_drop_cnt
`endif
);

  localparam int BW = $clog2(BUF_NUM);
  localparam int LW = $clog2(MAX_LINES);
  localparam logic [LW:0] PTR_ONE = (LW+1)'(1);
  localparam logic [LW:0] PTR_MAX = (LW+1)'(MAX_LINES);

  wr_state_e r_wst, w_wst_nxt;
  rd_state_e r_rst, w_rst_nxt;

  logic [ID_W-1:0]    r_cur_id;
  logic [BW-1:0]      w_cur_idx;
  logic [LW:0]        r_wr_ptr, w_wr_ptr_nxt;
  logic               r_bad, w_bad_nxt;
  logic [BUF_NUM-1:0] r_stored;
  logic [LW:0]        r_len [BUF_NUM];
  logic [133:0]       r_mem [BUF_NUM*MAX_LINES];

  logic               w_alloc, w_mem_we, w_wfree, w_commit;
  logic [BW+LW-1:0]   w_mem_waddr;
  logic [1:0]         w_drop_inc;
  logic [BW-1:0]      w_alloc_id;
  logic               w_any_free;
  logic [BUF_NUM-1:0] w_free_mask;

  logic [1:0]         w_type;
  logic               w_is_head, w_is_body, w_is_end;

  logic [BW-1:0]      r_rd_id;
  logic [LW:0]        r_rd_len, r_rd_ptr;
  logic               w_rd_ok, w_rd_accept, w_rd_err, w_rd_issue, w_rd_done;
  logic [133:0]       r_out_data;
  logic               r_out_data_wr, r_rd_err;

  assign w_cur_idx = r_cur_id[BW-1:0];
  assign w_type    = in_data[133:132];
  assign w_is_head = in_data_wr && (w_type == HEAD);
  assign w_is_body = in_data_wr && ((w_type == MID) || (w_type == TAIL));
  assign w_is_end  = in_data_wr && (w_type == TAIL) && in_valid_wr;

  always_comb begin
    w_wst_nxt    = r_wst;
    w_alloc      = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_waddr  = {w_cur_idx, r_wr_ptr[LW-1:0]};
    w_wr_ptr_nxt = r_wr_ptr;
    w_bad_nxt    = r_bad;
    w_wfree      = 1'b0;
    w_commit     = 1'b0;
    w_drop_inc   = 2'd0;
    unique case (r_wst)
      W_STORE: begin
        if (w_is_head) begin
          w_wfree    = 1'b1;
          w_drop_inc = w_drop_inc + 2'd1;
        end else if (w_is_body) begin
          if (r_wr_ptr == PTR_MAX) begin
            w_bad_nxt = 1'b1;
          end else begin
            w_mem_we     = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
          end
          if (w_is_end) begin
            w_wst_nxt = W_IDLE;
            if (in_valid && !w_bad_nxt) begin
              w_commit = 1'b1;
            end else begin
              w_wfree    = 1'b1;
              w_drop_inc = w_drop_inc + 2'd1;
            end
          end
        end
      end
      W_DROP:  if (w_is_end) w_wst_nxt = W_IDLE;
      default: ;
    endcase
    // A head in W_STORE aborts the old packet above, then starts fresh here.
    if (w_is_head && (r_wst != W_DROP)) begin
      if (w_any_free) begin
        w_alloc      = 1'b1;
        w_mem_we     = 1'b1;
        w_mem_waddr  = {w_alloc_id, {LW{1'b0}}};
        w_wr_ptr_nxt = PTR_ONE;
        w_bad_nxt    = 1'b0;
        w_wst_nxt    = W_STORE;
      end else begin
        w_drop_inc = w_drop_inc + 2'd1;
        w_wst_nxt  = W_DROP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wst    <= W_IDLE;
      r_cur_id <= '0;
      r_wr_ptr <= '0;
      r_bad    <= 1'b0;
    end else begin
      r_wst    <= w_wst_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_bad    <= w_bad_nxt;
      if (w_alloc) r_cur_id <= ID_W'(w_alloc_id);
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= in_data;
    if (w_commit) r_len[w_cur_idx] <= w_wr_ptr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stored <= '0;
    end else begin
      if (w_commit)  r_stored[w_cur_idx] <= 1'b1;
      if (w_rd_done) r_stored[r_rd_id]   <= 1'b0;
    end
  end

  always_comb begin
    w_free_mask = '0;
    if (w_wfree)   w_free_mask[w_cur_idx] = 1'b1;
    if (w_rd_done) w_free_mask[r_rd_id]   = 1'b1;
  end

  pkt_buf_free_map #(.BUF_NUM(BUF_NUM)) u_free_map (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_alloc     (w_alloc),
    .o_alloc_id  (w_alloc_id),
    .o_any_free  (w_any_free),
    .i_free_mask (w_free_mask),
    .o_free_cnt  (out_free_cnt)
  );

  assign w_rd_ok = (32'(rd_req_id) < BUF_NUM) && r_stored[rd_req_id[BW-1:0]];

  always_comb begin
    w_rst_nxt   = r_rst;
    w_rd_accept = 1'b0;
    w_rd_err    = 1'b0;
    w_rd_issue  = 1'b0;
    w_rd_done   = 1'b0;
    unique case (r_rst)
      R_IDLE: begin
        if (rd_req_wr) begin
          if (w_rd_ok) begin
            w_rd_accept = 1'b1;
            w_rst_nxt   = R_READ;
          end else begin
            w_rd_err = 1'b1;
          end
        end
      end
      R_READ: begin
        w_rd_err = rd_req_wr;
        if (r_rd_ptr < r_rd_len) begin
          w_rd_issue = 1'b1;
        end else begin
          w_rd_done = 1'b1;
          w_rst_nxt = R_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst         <= R_IDLE;
      r_rd_id       <= '0;
      r_rd_len      <= '0;
      r_rd_ptr      <= '0;
      r_out_data    <= '0;
      r_out_data_wr <= 1'b0;
      r_rd_err      <= 1'b0;
    end else begin
      r_rst         <= w_rst_nxt;
      r_out_data_wr <= w_rd_issue;
      r_rd_err      <= w_rd_err;
      if (w_rd_accept) begin
        r_rd_id  <= rd_req_id[BW-1:0];
        r_rd_len <= r_len[rd_req_id[BW-1:0]];
        r_rd_ptr <= '0;
      end
      if (w_rd_issue) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_out_data <= r_mem[{r_rd_id, r_rd_ptr[LW-1:0]}];
      end
    end
  end

  assign out_cur_id  = r_cur_id;
  assign out_data    = r_out_data;
  assign out_data_wr = r_out_data_wr;
  assign out_rd_err  = r_rd_err;

`ifdef PKT_BUF_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic [16:0] w_drop_sum;
  assign w_drop_sum = {1'b0, r_drop_cnt} + {15'b0, w_drop_inc};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_drop_cnt <= '0;
    else        r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end
  assign out_drop_cnt = r_drop_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = ^w_drop_inc;
`endif

endmodule
